// File: rtl/fpu_pkg.sv
// fpu_pkg: shared widths, FSM states, special constants and IEEE field helpers
package fpu_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIT_SIZE = EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [BIT_SIZE:0] QNAN = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  function automatic logic [EXP_W-1:0] exp_of(input logic [BIT_SIZE:0] x);
    return x[BIT_SIZE-1:MAN_W];
  endfunction
  function automatic logic [MAN_W-1:0] man_of(input logic [BIT_SIZE:0] x);
    return x[MAN_W-1:0];
  endfunction
  function automatic logic is_nan(input logic [BIT_SIZE:0] x);
    return exp_of(x) == EXP_MAX && man_of(x) != '0;
  endfunction
  function automatic logic is_inf(input logic [BIT_SIZE:0] x);
    return exp_of(x) == EXP_MAX && man_of(x) == '0;
  endfunction
  function automatic logic is_zero(input logic [BIT_SIZE:0] x);
    return exp_of(x) == '0;
  endfunction
endpackage

// File: rtl/fpu_round_rne.sv
// fpu_round_rne: round-to-nearest-even on a normalized mantissa with guard/round/sticky
module fpu_round_rne
  import fpu_pkg::*;
(
  input  logic [MAN_W:0]   man,
  input  logic             g,
  input  logic             r,
  input  logic             s,
  input  logic [EXP_W:0]   exp_in,
  output logic [MAN_W-1:0] frac,
  output logic [EXP_W-1:0] exp_r,
  output logic             ovf
);
  logic [MAN_W+1:0] inc;
  logic [EXP_W:0] exp_n;
  always_comb begin
    inc = {1'b0, man} + (MAN_W+2)'(g & (r | s | man[0]));
    exp_n = exp_in + (EXP_W+1)'(inc[MAN_W+1]);
    frac = inc[MAN_W+1] ? inc[MAN_W:1] : inc[MAN_W-1:0];
    exp_r = exp_n[EXP_W-1:0];
    ovf = exp_n >= {1'b0, EXP_MAX};
  end
endmodule

// File: rtl/fpu_add_sequencer.sv
// fpu_add_sequencer: multi-cycle IEEE add/sub sequenced through unpack, align, add, normalize and round
module fpu_add_sequencer
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic              add_sub,
  input  logic [BIT_SIZE:0] opa,
  input  logic [BIT_SIZE:0] opb,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [BIT_SIZE:0] sum,
  output logic              overflow,
  output logic              underflow,
  output logic              busy
);
  localparam int SW = MAN_W + 5;
  localparam logic [EXP_W-1:0] D_BIG = EXP_W'(MAN_W + 3);
  localparam logic [EXP_W-1:0] ONE_D = EXP_W'(1);
  localparam logic [EXP_W:0] ONE_E = (EXP_W+1)'(1);
  state_t state, state_n;
  logic [BIT_SIZE:0] ra, rb, fa, fb, hi, lo, sp_val;
  logic sa, sb, big, a_ge, sp_nan, sp;
  logic [EXP_W:0] e;
  logic [EXP_W-1:0] cnt, d;
  logic [MAN_W:0] ma;
  logic [MAN_W+3:0] mb;
  logic [SW-1:0] m, m_add;
  logic [MAN_W-1:0] r_frac;
  logic [EXP_W-1:0] r_exp;
  logic r_ovf;
  assign start_ready = state == IDLE;
  assign busy = state != IDLE;
  assign result_valid = state == DONE;
  always_comb begin
    fa = is_zero(ra) ? {ra[BIT_SIZE], {BIT_SIZE{1'b0}}} : ra;
    fb = is_zero(rb) ? {rb[BIT_SIZE], {BIT_SIZE{1'b0}}} : rb;
    a_ge = fa[BIT_SIZE-1:0] >= fb[BIT_SIZE-1:0];
    hi = a_ge ? fa : fb;
    lo = a_ge ? fb : fa;
    d = exp_of(hi) - exp_of(lo);
    sp_nan = is_nan(ra) || is_nan(rb) || (is_inf(ra) && is_inf(rb) && ra[BIT_SIZE] != rb[BIT_SIZE]);
    sp = sp_nan || is_inf(ra) || is_inf(rb) || (is_zero(ra) && is_zero(rb));
    sp_val = sp_nan ? QNAN : is_inf(ra) ? ra : is_inf(rb) ? rb : {ra[BIT_SIZE] & rb[BIT_SIZE], {BIT_SIZE{1'b0}}};
    m_add = sa == sb ? {1'b0, ma, 3'b0} + {1'b0, mb} : {1'b0, ma, 3'b0} - {1'b0, mb};
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start_valid ? UNPACK : IDLE;
      UNPACK:  state_n = sp ? DONE : ALIGN;
      ALIGN:   state_n = big || cnt <= ONE_D ? ADD : ALIGN;
      ADD:     state_n = m_add == '0 ? DONE : NORM;
      NORM:    state_n = m[SW-1] || m[SW-2] ? ROUND : e == ONE_E ? DONE : m[SW-3] ? ROUND : NORM;
      ROUND:   state_n = DONE;
      DONE:    state_n = result_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_valid) begin
          ra <= opa;
          rb <= {opb[BIT_SIZE] ^ ~add_sub, opb[BIT_SIZE-1:0]};
          overflow <= 1'b0;
          underflow <= 1'b0;
        end
        UNPACK: if (sp) sum <= sp_val;
        else begin
          sa <= hi[BIT_SIZE];
          sb <= lo[BIT_SIZE];
          e <= {1'b0, exp_of(hi)};
          ma <= {!is_zero(hi), man_of(hi)};
          mb <= {!is_zero(lo), man_of(lo), 3'b0};
          cnt <= d;
          big <= d > D_BIG;
        end
        ALIGN: if (big) mb <= {{(MAN_W+3){1'b0}}, |mb};
        else if (cnt != '0) begin
          mb <= {1'b0, mb[MAN_W+3:2], mb[1] | mb[0]};
          cnt <= cnt - ONE_D;
        end
        ADD: begin
          m <= m_add;
          if (m_add == '0) sum <= '0;
        end
        NORM: if (m[SW-1]) begin
          m <= {1'b0, m[SW-1:2], m[1] | m[0]};
          e <= e + ONE_E;
        end else if (!m[SW-2]) begin
          if (e == ONE_E) begin
            sum <= {sa, {BIT_SIZE{1'b0}}};
            underflow <= 1'b1;
          end else begin
            m <= m << 1;
            e <= e - ONE_E;
          end
        end
        ROUND: begin
          sum <= r_ovf ? {sa, EXP_MAX, {MAN_W{1'b0}}} : {sa, r_exp, r_frac};
          overflow <= r_ovf;
        end
        default: ;
      endcase
    end
  end
  fpu_round_rne u_round (
    .man(m[SW-2:3]),
    .g(m[2]),
    .r(m[1]),
    .s(m[0]),
    .exp_in(e),
    .frac(r_frac),
    .exp_r(r_exp),
    .ovf(r_ovf)
  );
endmodule

// File: tb/tb_fpu_add_sequencer.sv
// tb_fpu_add_sequencer: scoreboard bench for the sequenced IEEE single-precision adder
module tb_fpu_add_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_valid = 1'b0;
  logic add_sub = 1'b1;
  logic result_ready = 1'b1;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic start_ready, result_valid, overflow, underflow, busy;
  logic [31:0] sum;
  int checks = 0;
  int failures = 0;
  logic [33:0] q[$];
  string tq[$];
  logic [33:0] exp_m;
  string tag_m;
  always #5 clk = ~clk;
  fpu_add_sequencer dut (
    .clk(clk),
    .rst(rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .add_sub(add_sub),
    .opa(opa),
    .opb(opb),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .sum(sum),
    .overflow(overflow),
    .underflow(underflow),
    .busy(busy)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && result_valid && result_ready) begin
      check("sb_nonempty", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        exp_m = q.pop_front();
        tag_m = tq.pop_front();
        check({tag_m, "_sum"}, 64'(sum), 64'(exp_m[31:0]));
        check({tag_m, "_ovf"}, 64'(overflow), 64'(exp_m[33]));
        check({tag_m, "_unf"}, 64'(underflow), 64'(exp_m[32]));
      end
    end
  end
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic as, input logic [31:0] s,
                       input logic o, input logic u, input string tag, output int lat);
    check({tag, "_sready"}, 64'(start_ready), 64'd1);
    opa = a;
    opb = b;
    add_sub = as;
    start_valid = 1'b1;
    @(posedge clk);
    q.push_back({o, u, s});
    tq.push_back(tag);
    #1 start_valid = 1'b0;
    lat = 1;
    while (!result_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, "_valid"}, 64'(result_valid), 64'd1);
  endtask
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic as, input logic [31:0] s,
                     input logic o, input logic u, input int lat_e, input string tag);
    int lat;
    issue(a, b, as, s, o, u, tag, lat);
    if (lat_e > 0) check({tag, "_lat"}, 64'(lat), 64'(lat_e));
    @(posedge clk);
    #1;
  endtask
  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sready", 64'(start_ready), 64'd1);
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_flags", 64'({overflow, underflow}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run(32'h3F800000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0, 6, "one_plus_one");
    run(32'h3FC00000, 32'h3FC00000, 1'b0, 32'h00000000, 1'b0, 1'b0, 0, "x_minus_x");
    run(32'h3F800000, 32'h30800000, 1'b1, 32'h3F800000, 1'b0, 1'b0, 6, "sticky_only");
    run(32'h3F800000, 32'h33800000, 1'b1, 32'h3F800000, 1'b0, 1'b0, 0, "rne_tie_even");
    run(32'h3F800000, 32'h33C00000, 1'b1, 32'h3F800001, 1'b0, 1'b0, 0, "rne_up");
    run(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 32'h7F800000, 1'b1, 1'b0, 0, "overflow");
    run(32'h7FC00000, 32'h3F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b0, 2, "nan_in");
    run(32'h7F800000, 32'h7F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 2, "inf_minus_inf");
    run(32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 1'b0, 1'b0, 2, "inf_a");
    run(32'h3F800000, 32'h7F800000, 1'b0, 32'hFF800000, 1'b0, 1'b0, 2, "inf_b_sub");
    run(32'h80000000, 32'h80000000, 1'b1, 32'h80000000, 1'b0, 1'b0, 2, "negz_plus_negz");
    run(32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 2, "z_minus_z");
    run(32'h40000000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 0, "two_minus_one");
    run(32'hC0000000, 32'h3F800000, 1'b1, 32'hBF800000, 1'b0, 1'b0, 0, "neg_two_plus_one");
    run(32'h00400000, 32'h3F800000, 1'b1, 32'h3F800000, 1'b0, 1'b0, 0, "denorm_flush");
    run(32'h00800001, 32'h00800000, 1'b0, 32'h00000000, 1'b0, 1'b1, 0, "underflow");
    result_ready = 1'b0;
    issue(32'h3F800000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0, "hold", lat);
    opa = 32'h40400000;
    opb = 32'h40400000;
    start_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("hold_sum", 64'(sum), 64'h40000000);
      check("hold_sready", 64'(start_ready), 64'd0);
      check("hold_valid", 64'(result_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_idle_busy", 64'(busy), 64'd0);
    check("hold_idle_sready", 64'(start_ready), 64'd1);
    opa = 32'h3F800000;
    opb = 32'h33800000;
    add_sub = 1'b1;
    start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_sready", 64'(start_ready), 64'd1);
    check("abort_valid", 64'(result_valid), 64'd0);
    check("abort_sum", 64'(sum), 64'd0);
    check("abort_flags", 64'({overflow, underflow}), 64'd0);
    check("abort_busy_rst", 64'(busy), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run(32'h3F800000, 32'h33C00000, 1'b1, 32'h3F800001, 1'b0, 1'b0, 0, "after_abort");
    check("sb_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
